// File: rtl/cdbus_rs485_tx.sv
// Half-duplex RS485 byte transmitter: 8N1 frames from a valid/ready stream, with tx_en lead/tail guard.
// Optional CDBUS_RS485_TX_PARITY_EN inserts an even-parity bit (8E1).
module cdbus_rs485_tx #(
  parameter int DIV_W     = 16,
  parameter int PRE_BITS  = 1,
  parameter int POST_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             tx,
  output logic             tx_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5,
    TAIL   = 3'd6
  } state_t;

  localparam int GW = 16;
  localparam logic [GW-1:0] PRE_LAST  = (PRE_BITS  > 0) ? GW'(PRE_BITS - 1)  : '0;
  localparam logic [GW-1:0] POST_LAST = (POST_BITS > 0) ? GW'(POST_BITS - 1) : '0;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [GW-1:0]    guard_reg, guard_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             tx_en_reg, tx_en_next;
  logic             done_reg, done_next;
`ifdef CDBUS_RS485_TX_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  logic wrap;
  logic xfer;

  assign wrap      = (div_cnt_reg == div_reg);
  assign din_ready = (state_reg == IDLE) || (state_reg == TAIL) || ((state_reg == STOP) && wrap);
  assign xfer      = din_valid && din_ready;

  always_comb begin
    state_next   = state_reg;
    div_next     = div_reg;
    div_cnt_next = wrap ? '0 : div_cnt_reg + DIV_W'(1);
    bit_cnt_next = bit_cnt_reg;
    guard_next   = guard_reg;
    shift_next   = shift_reg;
    done_next    = 1'b0;
`ifdef CDBUS_RS485_TX_PARITY_EN
    parity_next  = parity_reg;
`endif

    case (state_reg)
      IDLE: begin
        div_cnt_next = '0;
        if (xfer) begin
          // The bit period is frozen for the whole burst from this point on.
          div_next   = div;
          shift_next = din;
`ifdef CDBUS_RS485_TX_PARITY_EN
          parity_next = ^din;
`endif
          guard_next = '0;
          state_next = (PRE_BITS > 0) ? LEAD : START;
        end
      end
      LEAD: begin
        if (wrap) begin
          if (guard_reg == PRE_LAST) begin
            guard_next = '0;
            state_next = START;
          end else begin
            guard_next = guard_reg + GW'(1);
          end
        end
      end
      START: begin
        if (wrap) begin
          bit_cnt_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (wrap) begin
          if (bit_cnt_reg == 3'd7) begin
`ifdef CDBUS_RS485_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end
      end
`ifdef CDBUS_RS485_TX_PARITY_EN
      PARITY: begin
        if (wrap) state_next = STOP;
      end
`endif
      STOP: begin
        if (wrap) begin
          if (xfer) begin
            shift_next = din;
`ifdef CDBUS_RS485_TX_PARITY_EN
            parity_next = ^din;
`endif
            state_next = START;
          end else if (POST_BITS > 0) begin
            guard_next = '0;
            state_next = TAIL;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      TAIL: begin
        if (xfer) begin
          // A byte arriving during the tail restarts the bit timing immediately.
          shift_next = din;
`ifdef CDBUS_RS485_TX_PARITY_EN
          parity_next = ^din;
`endif
          div_cnt_next = '0;
          state_next   = START;
        end else if (wrap) begin
          if (guard_reg == POST_LAST) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            guard_next = guard_reg + GW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    tx_next    = 1'b1;
    tx_en_next = (state_next != IDLE);
    case (state_next)
      START:  tx_next = 1'b0;
      DATA:   tx_next = shift_next[0];
`ifdef CDBUS_RS485_TX_PARITY_EN
      PARITY: tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      div_reg     <= '0;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      guard_reg   <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      tx_en_reg   <= 1'b0;
      done_reg    <= 1'b0;
`ifdef CDBUS_RS485_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      div_cnt_reg <= div_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      guard_reg   <= guard_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      tx_en_reg   <= tx_en_next;
      done_reg    <= done_next;
`ifdef CDBUS_RS485_TX_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  assign tx    = tx_reg;
  assign tx_en = tx_en_reg;
  assign busy  = (state_reg != IDLE);
  assign done  = done_reg;

endmodule

// File: tb/tb_cdbus_rs485_tx.sv
// Directed bench for cdbus_rs485_tx: three instances covering lead/tail guard variants.
module tb_cdbus_rs485_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div_v   [3];
  logic [7:0]  din_v   [3];
  logic        valid_v [3];
  logic        ready_w [3];
  logic        tx_w    [3];
  logic        tx_en_w [3];
  logic        busy_w  [3];
  logic        done_w  [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cdbus_rs485_tx #(.DIV_W(16), .PRE_BITS(1), .POST_BITS(1)) u0 (
    .clk(clk), .rst(rst), .div(div_v[0]), .din(din_v[0]), .din_valid(valid_v[0]),
    .din_ready(ready_w[0]), .tx(tx_w[0]), .tx_en(tx_en_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  cdbus_rs485_tx #(.DIV_W(16), .PRE_BITS(0), .POST_BITS(0)) u1 (
    .clk(clk), .rst(rst), .div(div_v[1]), .din(din_v[1]), .din_valid(valid_v[1]),
    .din_ready(ready_w[1]), .tx(tx_w[1]), .tx_en(tx_en_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  cdbus_rs485_tx #(.DIV_W(16), .PRE_BITS(1), .POST_BITS(2)) u2 (
    .clk(clk), .rst(rst), .div(div_v[2]), .din(din_v[2]), .din_valid(valid_v[2]),
    .din_ready(ready_w[2]), .tx(tx_w[2]), .tx_en(tx_en_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check one in-burst cycle, then move to the next sample point.
  task automatic cyc(input int u, input string tag, input logic etx, input logic erdy);
    chk({tag, " tx"}, tx_w[u], etx);
    chk({tag, " tx_en"}, tx_en_w[u], 1'b1);
    chk({tag, " busy"}, busy_w[u], 1'b1);
    chk({tag, " done"}, done_w[u], 1'b0);
    chk({tag, " ready"}, ready_w[u], erdy);
    @(negedge clk);
  endtask

  task automatic level(input int u, input string tag, input int n, input logic erdy);
    for (int i = 0; i < n; i++) cyc(u, $sformatf("%s c%0d", tag, i), 1'b1, erdy);
  endtask

  task automatic frame(input int u, input string tag, input logic [7:0] b, input int d);
    logic [10:0] bits;
    int nb;
`ifdef CDBUS_RS485_TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
    nb   = 11;
`else
    bits = {2'b00, 1'b1, b, 1'b0};
    nb   = 10;
`endif
    for (int k = 0; k < nb; k++)
      for (int c = 0; c <= d; c++)
        cyc(u, $sformatf("%s b%0d c%0d", tag, k, c), bits[k], (k == nb - 1) && (c == d));
  endtask

  task automatic idle_chk(input int u, input string tag);
    chk({tag, " tx"}, tx_w[u], 1'b1);
    chk({tag, " tx_en"}, tx_en_w[u], 1'b0);
    chk({tag, " busy"}, busy_w[u], 1'b0);
    chk({tag, " ready"}, ready_w[u], 1'b1);
  endtask

  task automatic finish_burst(input int u, input string tag);
    idle_chk(u, tag);
    chk({tag, " done"}, done_w[u], 1'b1);
    @(negedge clk);
    chk({tag, " done clr"}, done_w[u], 1'b0);
    chk({tag, " tx_en clr"}, tx_en_w[u], 1'b0);
  endtask

  task automatic accept(input int u, input logic [7:0] b, input logic [15:0] d);
    din_v[u]   = b;
    div_v[u]   = d;
    valid_v[u] = 1'b1;
    chk("accept ready", ready_w[u], 1'b1);
    @(negedge clk);
    valid_v[u] = 1'b0;
    din_v[u]   = 8'hXX;
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      div_v[u] = '0; din_v[u] = '0; valid_v[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      idle_chk(u, $sformatf("reset u%0d", u));
      chk($sformatf("reset u%0d done", u), done_w[u], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Single byte, div=3, lead 1, tail 1; div changed mid-burst must be ignored.
    accept(0, 8'h55, 16'd3);
    div_v[0] = 16'd0;
    level(0, "s1 lead", 4, 1'b0);
    frame(0, "s1", 8'h55, 3);
    level(0, "s1 tail", 4, 1'b1);
    finish_burst(0, "s1 end");
    $display("txn single 0x55 div=3 done");

    // Back-to-back with din_valid held, div=1.
    din_v[0] = 8'hA3; div_v[0] = 16'd1; valid_v[0] = 1'b1;
    chk("b2b accept ready", ready_w[0], 1'b1);
    @(negedge clk);
    din_v[0] = 8'h0F;
    level(0, "b2b lead", 2, 1'b0);
    frame(0, "b2b f1", 8'hA3, 1);
    valid_v[0] = 1'b0;
    frame(0, "b2b f2", 8'h0F, 1);
    level(0, "b2b tail", 2, 1'b1);
    finish_burst(0, "b2b end");
    $display("txn back-to-back 0xA3,0x0F div=1 done");

    // Byte offered at the third tail cycle, div=2, tail 2 bits.
    accept(2, 8'h3C, 16'd2);
    level(2, "tl lead", 3, 1'b0);
    frame(2, "tl f1", 8'h3C, 2);
    level(2, "tl tail", 2, 1'b1);
    din_v[2] = 8'hC5; valid_v[2] = 1'b1;
    cyc(2, "tl tail3", 1'b1, 1'b1);
    valid_v[2] = 1'b0;
    frame(2, "tl f2", 8'hC5, 2);
    level(2, "tl tail2", 6, 1'b1);
    finish_burst(2, "tl end");
    $display("txn tail-restart 0x3C,0xC5 div=2 done");

    // No lead, no tail, div=0.
    accept(1, 8'hFF, 16'd0);
    frame(1, "p0", 8'hFF, 0);
    finish_burst(1, "p0 end");
    $display("txn no-guard 0xFF div=0 done");

    // Asynchronous reset during data bit 4, then a clean frame.
    accept(0, 8'h45, 16'd3);
    repeat (24) @(negedge clk);
    chk("rst pre tx_en", tx_en_w[0], 1'b1);
    chk("rst pre tx bit4", tx_w[0], 1'b0);
    #2 rst = 1'b1;
    #1;
    idle_chk(0, "rst async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idle_chk(0, "rst after");
    accept(0, 8'h96, 16'd3);
    level(0, "rst lead", 4, 1'b0);
    frame(0, "rst f", 8'h96, 3);
    level(0, "rst tail", 4, 1'b1);
    finish_burst(0, "rst end");
    $display("txn reset-abort then 0x96 done");

    // Parity candidate byte (0x07 -> even parity bit 1 when enabled).
    accept(0, 8'h07, 16'd3);
    level(0, "par lead", 4, 1'b0);
    frame(0, "par", 8'h07, 3);
    level(0, "par tail", 4, 1'b1);
    finish_burst(0, "par end");
    $display("txn 0x07 div=3 done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdbus_rs485_tx.md
Name: cdbus_rs485_tx

Overview:
- Half-duplex RS485 byte transmitter feeding the board's tx / tx_en pins.
- Serialises 8N1 UART frames from a valid/ready byte stream.
- Drives the transceiver enable with programmable lead and tail guard time.
- Sits between the packet framer (upstream) and the pin-level tx/tx_en outputs of the board top.

Parameters:
DIV_W, 16, width of the bit-period divisor input
PRE_BITS, 1, bit periods tx_en is asserted with tx idle-high before the first start bit (0 = no lead)
POST_BITS, 1, bit periods tx_en is held after the last stop bit (0 = release right after the stop bit)

Ports:
clk  input  1  system clock (PLL global output)
rst  input  1  asynchronous, active-high reset
div  input  DIV_W  clocks per bit minus 1; bit period = div+1 cycles
din  input  8  byte to send
din_valid  input  1  din holds a byte
din_ready  output  1  block accepts din this cycle
tx  output  1  serial data, idle high, LSB first
tx_en  output  1  RS485 driver enable
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when tx_en falls at end of burst

Behaviour:
- Reset (async, active-high): state=IDLE, tx=1, tx_en=0, busy=0, done=0, bit counter=0, divisor counter=0. din_ready=1 in IDLE, so its reset value is 1.
- Handshake: transfer occurs on posedge when din_valid && din_ready.
  - din_ready=1 in IDLE, in TAIL, and in the last clock of the STOP bit; 0 otherwise.
  - din is captured into an 8-bit shift register on transfer.
  - din may change freely while din_ready=0.
- div is latched on the IDLE transfer and held for the whole burst. Changes to div mid-burst have no effect. div=0 gives 1-cycle bits.
- States and transitions:
  - IDLE: tx=1, tx_en=0. On transfer: tx_en=1 next cycle; go to LEAD if PRE_BITS>0, else START.
  - LEAD: tx=1, tx_en=1, lasts PRE_BITS*(div+1) cycles, then START.
  - START: tx=0 for div+1 cycles, then DATA.
  - DATA: 8 bits LSB first, each div+1 cycles; shift right per bit; then STOP.
  - STOP: tx=1 for div+1 cycles.
    - Transfer in its last cycle: go to START (back-to-back, no lead, no tail, no idle gap).
    - Otherwise: go to TAIL if POST_BITS>0, else IDLE.
  - TAIL: tx=1, tx_en=1, lasts POST_BITS*(div+1) cycles.
    - Transfer in any TAIL cycle: go to START next cycle; tx_en stays 1, no lead.
    - On expiry: go to IDLE, tx_en=0, done=1 for that one cycle.
  - STOP with POST_BITS=0 and no transfer: go to IDLE; done pulses on the cycle tx_en falls.
- Latency: IDLE transfer at edge N gives tx_en=1 at N+1. The start-bit falling edge is at N+1+PRE_BITS*(div+1).
- Counters:
  - Divisor counter counts 0..div and wraps; the bit advances on wrap.
  - Bit counter 0..7 in DATA.
  - Lead/tail counter counts bit periods up to PRE_BITS/POST_BITS.
- tx and tx_en are registered outputs (no combinational path from inputs).
- din_valid dropping without transfer has no effect. A transfer cannot be cancelled; the frame always completes.
- An rst assertion mid-frame aborts immediately: tx=1 and tx_en=0 asynchronously, and the partial frame is discarded.

Optional Feature:
- Macro: CDBUS_RS485_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It lasts one bit period with tx = even parity (XOR of the 8 data bits). The frame is 8E1, 11 bits.
- Undefined: no PARITY state, 8N1, 10 bits.
- All handshake and timing rules are otherwise identical.

Test Plan:
- Single byte, div=3, PRE=1, POST=1, din=0x55 -> tx_en high 1 cycle after accept; 4 cycles lead; tx = 0,1,0,1,0,1,0,1,0,1 (4 cycles each) then 4-cycle tail; done pulse; total tx_en high 48 cycles.
- Back-to-back 0xA3 then 0x0F with din_valid held, div=1 -> second byte accepted in the last STOP cycle; its start bit immediately follows the stop bit; single lead and single tail; one done pulse.
- Byte offered during TAIL (div=2, POST=2, at 3rd tail cycle) -> START next cycle; tx_en never drops; no done until the second frame's tail expires.
- div=0, PRE_BITS=0, POST_BITS=0, din=0xFF -> start bit 1 cycle after accept; 10-cycle frame; tx_en low and done=1 on the cycle after the stop bit.
- rst pulsed during DATA bit 4 -> tx=1, tx_en=0, busy=0, din_ready=1 asynchronously; next byte sends a clean full frame.
- With CDBUS_RS485_TX_PARITY_EN defined, din=0x07, div=3 -> parity bit = 1 after bit 7; 11-bit frame; undefined build gives a 10-bit frame.
